// File: rtl/mc_beq_control_if.sv
// ============================================================================
// mc_beq_control_if : instruction handshake and datapath control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mc_beq_control_if #(
  parameter int PC_W = 32
) ();

  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [4:0]      rd_reg1;
  logic [4:0]      rd_reg2;
  logic [4:0]      wr_reg;
  logic            wr_enable;
  logic [5:0]      alu_op;
  logic            zero;
  logic            retire;
  logic            branch_taken;
  logic            illegal;

  // Sequencer side
  modport master (
    input  instr_valid, instr, zero,
    output instr_ready, pc, rd_reg1, rd_reg2, wr_reg, wr_enable, alu_op,
           retire, branch_taken, illegal
  );

  // Instruction source / datapath side
  modport slave (
    output instr_valid, instr, zero,
    input  instr_ready, pc, rd_reg1, rd_reg2, wr_reg, wr_enable, alu_op,
           retire, branch_taken, illegal
  );

endinterface

`default_nettype wire

// File: rtl/mc_beq_control.sv
// ============================================================================
// mc_beq_control : multi-cycle sequencer for R-type ALU ops and beq
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_beq_control #(
  parameter int PC_W = 32
) (
  input  wire                 clk,
  input  wire                 rst_n,
  mc_beq_control_if.master    bus
);

  localparam logic [5:0] c_op_rtype   = 6'h00;
  localparam logic [5:0] c_op_beq     = 6'h04;
  localparam logic [5:0] c_funct_add  = 6'h20;
  localparam logic [5:0] c_funct_sub  = 6'h22;
  localparam logic [5:0] c_funct_and  = 6'h24;
  localparam logic [5:0] c_funct_or   = 6'h25;
  localparam logic [5:0] c_funct_slt  = 6'h2A;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [5:0]      alu_op_q, alu_op_d;

  logic            instr_ready;
  logic            wr_enable;
  logic            retire;
  logic            branch_taken;
  logic            illegal;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            is_rtype;
  logic            is_beq;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pc_branch;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign is_beq   = (opcode == c_op_beq);
  assign is_rtype = (opcode == c_op_rtype) &&
                    ((funct == c_funct_add) || (funct == c_funct_sub) ||
                     (funct == c_funct_and) || (funct == c_funct_or)  ||
                     (funct == c_funct_slt));

  // Word offset sign-extended to PC_W then scaled to bytes
  if (PC_W > 18) begin : g_off_wide
    assign br_off = {{(PC_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  end else begin : g_off_exact
    assign br_off = {ir_q[15:0], 2'b00};
  end

  assign pc_plus4  = pc_q + PC_W'(4);
  assign pc_branch = pc_plus4 + br_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      alu_op_q <= alu_op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    alu_op_d     = alu_op_q;
    instr_ready  = 1'b0;
    wr_enable    = 1'b0;
    retire       = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (is_rtype) begin
          alu_op_d = funct;
          state_d  = EXEC;
        end else if (is_beq) begin
          alu_op_d = c_funct_sub;
          state_d  = EXEC;
        end else begin
          // Unsupported encodings retire here without touching alu_op
          retire  = 1'b1;
          illegal = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      EXEC: begin
        if (is_beq) begin
          retire  = 1'b1;
          state_d = FETCH;
          if (bus.zero) begin
            branch_taken = 1'b1;
            pc_d         = pc_branch;
          end else begin
            pc_d         = pc_plus4;
          end
        end else begin
          state_d = WB;
        end
      end

      WB: begin
        wr_enable = 1'b1;
        retire    = 1'b1;
        pc_d      = pc_plus4;
        state_d   = FETCH;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign bus.instr_ready  = instr_ready;
  assign bus.pc           = pc_q;
  assign bus.rd_reg1      = ir_q[25:21];
  assign bus.rd_reg2      = ir_q[20:16];
  assign bus.wr_reg       = ir_q[15:11];
  assign bus.wr_enable    = wr_enable;
  assign bus.alu_op       = alu_op_q;
  assign bus.retire       = retire;
  assign bus.branch_taken = branch_taken;
  assign bus.illegal      = illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_beq_control.sv
// ============================================================================
// tb_mc_beq_control : directed bench with retire scoreboard for mc_beq_control
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_beq_control;

  localparam int PC_W = 32;

  typedef struct {
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        taken;
    logic        ill;
    logic        wen;
    logic [5:0]  alu;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mc_beq_control_if #(.PC_W(PC_W)) bus ();

  mc_beq_control #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_pc;
  logic [5:0]  m_alu;
  logic [31:0] prog [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: predicts the retire record and latency of one instruction
  task automatic push(input logic [31:0] i, input logic z, output int lat);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] off;
    op        = i[31:26];
    fn        = i[5:0];
    off       = {{14{i[15]}}, i[15:0], 2'b00};
    e.pc_cur  = m_pc;
    e.taken   = 1'b0;
    e.ill     = 1'b0;
    e.wen     = 1'b0;
    e.r1      = i[25:21];
    e.r2      = i[20:16];
    e.wr      = i[15:11];
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                        fn == 6'h25 || fn == 6'h2A)) begin
      e.wen     = 1'b1;
      m_alu     = fn;
      lat       = 4;
      e.pc_next = m_pc + 32'd4;
    end else if (op == 6'h04) begin
      m_alu     = 6'h22;
      lat       = 3;
      e.taken   = z;
      e.pc_next = z ? (m_pc + 32'd4 + off) : (m_pc + 32'd4);
    end else begin
      e.ill     = 1'b1;
      lat       = 2;
      e.pc_next = m_pc + 32'd4;
    end
    e.alu = m_alu;
    m_pc  = e.pc_next;
    sb.push_back(e);
  endtask

  task automatic run(input logic [31:0] i, input logic z, input string tag);
    int lat;
    int n;
    chk({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
    push(i, z, lat);
    bus.zero        = z;
    bus.instr       = i;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hFFFF_FFFF;
    n = 1;
    while (!bus.instr_ready && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.zero        = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_pc  = 32'h0;
    m_alu = 6'h0;
  endtask

  // Scoreboard: every retire pulse is matched against the oldest prediction
  always @(negedge clk) begin
    if (rst_n && bus.retire) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_retire", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc",     bus.pc,                  mon_e.pc_cur);
        chk("sb_taken",  32'(bus.branch_taken),   32'(mon_e.taken));
        chk("sb_ill",    32'(bus.illegal),        32'(mon_e.ill));
        chk("sb_wen",    32'(bus.wr_enable),      32'(mon_e.wen));
        chk("sb_alu",    32'(bus.alu_op),         32'(mon_e.alu));
        chk("sb_rd1",    32'(bus.rd_reg1),        32'(mon_e.r1));
        chk("sb_rd2",    32'(bus.rd_reg2),        32'(mon_e.r2));
        if (mon_e.wen) chk("sb_wr_reg", 32'(bus.wr_reg), 32'(mon_e.wr));
        @(posedge clk);
        #1;
        if (rst_n) chk("sb_pc_next", bus.pc, mon_e.pc_next);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int idx;
    int cyc;
    int last;
    int lat_q[$];

    // Reset
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.zero        = 1'b0;
    repeat (3) tick();
    chk("rst_hold_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_hold_pc",    bus.pc,               32'h0);
    #2 rst_n = 1'b1;
    m_pc  = 32'h0;
    m_alu = 6'h0;
    tick();
    chk("rst_pc",     bus.pc,                   32'h0);
    chk("rst_ready",  32'(bus.instr_ready),     32'd1);
    chk("rst_wen",    32'(bus.wr_enable),       32'd0);
    chk("rst_retire", 32'(bus.retire),          32'd0);
    chk("rst_taken",  32'(bus.branch_taken),    32'd0);
    chk("rst_ill",    32'(bus.illegal),         32'd0);
    chk("rst_alu",    32'(bus.alu_op),          32'd0);

    // add $3,$1,$2 at pc=0, cycle by cycle
    push(32'h0022_1820, 1'b0, lat);
    bus.instr       = 32'h0022_1820;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hFFFF_FFFF;
    chk("add_c1_rd1",    32'(bus.rd_reg1),     32'd1);
    chk("add_c1_rd2",    32'(bus.rd_reg2),     32'd2);
    chk("add_c1_ready",  32'(bus.instr_ready), 32'd0);
    chk("add_c1_wen",    32'(bus.wr_enable),   32'd0);
    tick();
    chk("add_c2_alu",    32'(bus.alu_op),      32'h20);
    chk("add_c2_wen",    32'(bus.wr_enable),   32'd0);
    tick();
    chk("add_c3_wen",    32'(bus.wr_enable),   32'd1);
    chk("add_c3_wr_reg", 32'(bus.wr_reg),      32'd3);
    chk("add_c3_retire", 32'(bus.retire),      32'd1);
    chk("add_c3_pc",     bus.pc,               32'h0);
    tick();
    chk("add_c4_pc",     bus.pc,               32'h4);
    chk("add_c4_wen",    32'(bus.wr_enable),   32'd0);
    chk("add_c4_ready",  32'(bus.instr_ready), 32'd1);

    // sub to reach pc=8
    run(32'h0022_1822, 1'b0, "sub");

    // beq taken at pc=8, cycle by cycle
    push(32'h1022_0003, 1'b1, lat);
    bus.zero        = 1'b1;
    bus.instr       = 32'h1022_0003;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hFFFF_FFFF;
    chk("beq_c1_retire", 32'(bus.retire),       32'd0);
    tick();
    chk("beq_c2_retire", 32'(bus.retire),       32'd1);
    chk("beq_c2_taken",  32'(bus.branch_taken), 32'd1);
    chk("beq_c2_wen",    32'(bus.wr_enable),    32'd0);
    chk("beq_c2_alu",    32'(bus.alu_op),       32'h22);
    tick();
    chk("beq_c3_pc",     bus.pc,                32'd24);
    chk("beq_c3_taken",  32'(bus.branch_taken), 32'd0);
    chk("beq_c3_ready",  32'(bus.instr_ready),  32'd1);

    // Backward branch to pc=8, then beq not taken
    run(32'h1000_FFFB, 1'b1, "beq_back");
    chk("beq_back_pc", bus.pc, 32'd8);
    run(32'h1022_0003, 1'b0, "beq_nt");
    chk("beq_nt_pc", bus.pc, 32'd12);

    // Wrap-around below zero
    do_reset();
    run(32'h1000_FFFE, 1'b1, "wrap");
    chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);

    // Illegal lw at 0xFFFFFFFC, cycle by cycle
    push(32'h8C22_0000, 1'b0, lat);
    bus.instr       = 32'h8C22_0000;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hFFFF_FFFF;
    chk("lw_c1_ill",    32'(bus.illegal),     32'd1);
    chk("lw_c1_retire", 32'(bus.retire),      32'd1);
    chk("lw_c1_wen",    32'(bus.wr_enable),   32'd0);
    chk("lw_c1_alu",    32'(bus.alu_op),      32'h22);
    tick();
    chk("lw_c2_pc",     bus.pc,               32'h0);
    chk("lw_c2_ill",    32'(bus.illegal),     32'd0);
    chk("lw_c2_ready",  32'(bus.instr_ready), 32'd1);

    // All-zero word is an illegal funct
    run(32'h0000_0000, 1'b0, "nop_word");

    // Back-to-back with instr_valid held high; non-FETCH cycles carry junk
    prog[0] = 32'h0022_1824;
    prog[1] = 32'h0022_1825;
    prog[2] = 32'h0022_182A;
    prog[3] = 32'h1000_0001;
    prog[4] = 32'h8C22_0000;
    prog[5] = 32'h0022_1822;
    bus.zero        = 1'b1;
    bus.instr_valid = 1'b1;
    idx  = 0;
    cyc  = 0;
    last = 0;
    while (idx < 6 && cyc < 60) begin
      if (bus.instr_ready) begin
        if (idx > 0) chk("b2b_spacing", 32'(cyc - last), 32'(lat_q.pop_front()));
        last      = cyc;
        bus.instr = prog[idx];
        push(prog[idx], 1'b1, lat);
        lat_q.push_back(lat);
        idx++;
      end else begin
        bus.instr = 32'hFFFF_FFFF;
      end
      tick();
      cyc++;
    end
    while (!bus.instr_ready && cyc < 80) begin
      bus.instr = 32'hFFFF_FFFF;
      tick();
      cyc++;
    end
    bus.instr_valid = 1'b0;
    chk("b2b_accepted",     32'(idx),        32'd6);
    chk("b2b_spacing_last", 32'(cyc - last), 32'(lat_q.pop_front()));
    chk("b2b_pc",           bus.pc,          32'd32);

    // Reset while WB is driving wr_enable
    bus.instr       = 32'h0022_1820;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    chk("mid_wb_wen_before", 32'(bus.wr_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wb_wen_async",  32'(bus.wr_enable),   32'd0);
    chk("mid_wb_retire",     32'(bus.retire),      32'd0);
    chk("mid_wb_pc",         bus.pc,               32'h0);
    chk("mid_wb_ready",      32'(bus.instr_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    m_pc  = 32'h0;
    m_alu = 6'h0;
    tick();
    run(32'h0022_1820, 1'b0, "post_rst_add");
    chk("post_rst_pc", bus.pc, 32'h4);

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_beq_control.md
# mc_beq_control

Multi-cycle control sequencer that drives the register-file/ALU datapath from the other side. It accepts one 32-bit MIPS instruction at a time over a valid/ready handshake and decodes R-type ALU operations and `beq`. It then sequences the datapath's read/write register addresses, ALU function code and write strobe over several cycles. It owns the program counter and resolves `beq` from the datapath's `zero` flag.

## Interface
- `PC_W`, default 32: program counter width in bits; legal range 18..32.
- `clk`  input  1: single clock, all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `instr_valid`  input  1: the instruction source presents `instr`.
- `instr`  input  32: the instruction word.
- `instr_ready`  output  1: the sequencer can accept an instruction.
- `pc`  output  PC_W: address of the instruction currently requested or executing.
- `rd_reg1`  output  5: datapath read port 1 address, equal to IR[25:21] (rs).
- `rd_reg2`  output  5: datapath read port 2 address, equal to IR[20:16] (rt).
- `wr_reg`  output  5: datapath write address, equal to IR[15:11] (rd).
- `wr_enable`  output  1: datapath register write strobe.
- `alu_op`  output  6: ALU function code sent to the datapath.
- `zero`  input  1: ALU zero flag returned by the datapath, combinational from `rd_reg1`, `rd_reg2` and `alu_op`.
- `retire`  output  1: one-cycle pulse when an instruction completes.
- `branch_taken`  output  1: one-cycle pulse, coincident with `retire`, when a `beq` is taken.
- `illegal`  output  1: one-cycle pulse, coincident with `retire`, for an unsupported instruction.

## Operation
- States: FETCH, DECODE, EXEC, WB. Encoding is free; FETCH is the reset state.
- Instruction register IR is PC_W-independent, 32 bits, reset value 0. `rd_reg1`, `rd_reg2` and `wr_reg` are combinational slices of IR.
- FETCH:
  - `instr_ready`=1 only in this state.
  - When `instr_valid`=1, IR<=`instr` and the next state is DECODE. Otherwise remain in FETCH.
  - `instr` is ignored in every other state, even if `instr_valid`=1.
- DECODE:
  - Opcode IR[31:26]=0 with funct IR[5:0] in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}: `alu_op`<=funct, next state EXEC.
  - Opcode 0x04 (`beq`): `alu_op`<=0x22, next state EXEC.
  - Anything else, including funct 0x00 (so 0x00000000 is illegal): pulse `retire` and `illegal`, pc<=pc+4, next state FETCH. `alu_op` is unchanged.
- EXEC:
  - R-type: next state WB.
  - `beq`: sample `zero`.
    - If `zero`=1: pc<=pc+4+(sext(IR[15:0])<<2) and pulse `branch_taken`.
    - Else pc<=pc+4.
    - In both cases pulse `retire` and go to FETCH.
- WB: `wr_enable`=1 for exactly this one cycle. Then pulse `retire`, pc<=pc+4, next state FETCH.
- `wr_enable` is a Moore output of state WB. It is never asserted for `beq` or illegal instructions.
- Arithmetic:
  - All pc arithmetic is modulo 2^PC_W; wrap-around is silent.
  - The branch offset is sign-extended from 16 bits to PC_W, then shifted left by 2.
- Reset values: state=FETCH, pc=0, IR=0, `alu_op`=0, `instr_ready`=1, `wr_enable`=0, `retire`=0, `branch_taken`=0, `illegal`=0.
- Reset asserted mid-instruction: all registers clear immediately and asynchronously. `wr_enable` drops in the same cycle and the instruction is abandoned with no retire. The first instruction after release is fetched at pc=0.

## Timing
- Handshake edge = cycle 0, i.e. the edge where FETCH sees `instr_valid`=1.
- R-type:
  - DECODE in cycle 1.
  - EXEC in cycle 2; `alu_op` is valid from here.
  - WB in cycle 3 with `wr_enable`=1 and `retire`=1.
  - FETCH and the new pc are visible in cycle 4. Throughput is 4 cycles per instruction.
- `beq`:
  - DECODE in cycle 1.
  - EXEC in cycle 2: `zero` is sampled at the end of this cycle, and `retire` and `branch_taken` are asserted.
  - New pc and FETCH in cycle 3.
- Illegal: `retire` and `illegal` in cycle 1; FETCH in cycle 2.
- `alu_op` holds its value through FETCH until the next DECODE.
- `pc` changes only on the retiring edge.

## Test plan
- Reset: hold `rst_n`=0 across several edges, then release. Required: pc=0, `instr_ready`=1, and `wr_enable`, `retire`, `branch_taken`, `illegal` all 0; `alu_op`=0.
- Add: `instr`=0x00221820 (add $3,$1,$2) at pc=0. Required:
  - `rd_reg1`=1, `rd_reg2`=2 from cycle 1; `alu_op`=0x20 from cycle 2.
  - `wr_enable`=1 and `wr_reg`=3 in cycle 3 only.
  - pc=4 in cycle 4.
- Branch taken and not taken: 0x10220003 at pc=8.
  - With `zero`=1: pc becomes 24 and `branch_taken` pulses for one cycle.
  - With `zero`=0: pc becomes 12 and `branch_taken` stays 0.
  - `wr_enable` stays 0 in both cases.
- Wrap-around: 0x1000FFFE at pc=0 with `zero`=1. Required: pc becomes 0xFFFFFFFC when PC_W=32.
- Illegal and back-to-back: 0x8C220000 (lw). Required:
  - `illegal` and `retire` pulse in cycle 1, no `wr_enable`, pc+4.
  - Hold `instr_valid`=1 continuously: instructions are accepted only in FETCH cycles, and `instr_ready` is 0 otherwise.
- Reset mid-WB: assert `rst_n`=0 while `wr_enable`=1. Required: `wr_enable` falls without waiting for a clock edge, pc=0, no `retire` pulse, state returns to FETCH.
